ball_motion: RTL and testbench
==============================

Name: ball_motion

Overview:
Frame-paced ball position sequencer for the air-hockey datapath. It holds the ball's top-left coordinates and advances them once per frame tick using the direction flags from the collision stage. It feeds x_ball/y_ball and a one-cycle collision enable back to the collision stage. Each move is wrapped in an erase/redraw handshake with the VGA box drawer.

Parameters:
FRAME_CYCLES, 833333, clocks per frame tick (60 Hz at 50 MHz); must be at least 2
STEP, 1, pixels moved per axis per frame
BALL_SIZE, 4, ball box edge in pixels
SCREEN_W, 320, screen width in pixels
SCREEN_H, 240, screen height in pixels
START_X, 158, serve x coordinate
START_Y, 118, serve y coordinate

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous, active-low reset
serve  in  1  start or restart the ball; level, sampled in IDLE/HALT
horizontal  in  1  from collision: 1 = move right (+x), 0 = move left (-x)
vertical  in  1  from collision: 1 = move up (-y), 0 = move down (+y)
stop  in  1  from collision: goal condition
draw_done  in  1  drawer finished the current box; 1-cycle pulse
x_ball  out  11  ball top-left x
y_ball  out  11  ball top-left y
coll_enable  out  1  1-cycle pulse; collision stage evaluates on this edge
draw_req  out  1  box draw request; held until draw_done
erase  out  1  qualifies draw_req: 1 = draw background colour, 0 = draw ball colour
halted  out  1  ball stopped after a goal

Behaviour:
- States: IDLE, WAIT, ERASE, MOVE, DRAW, COLL, HALT.
- Reset applies when reset_n is 0 at a clock edge, from any state including mid-handshake:
  - state goes to IDLE; x_ball=START_X, y_ball=START_Y.
  - draw_req=0, erase=0, coll_enable=0, halted=0, frame counter=0.
- IDLE: when serve=1, load START_X/START_Y and go to DRAW.
- WAIT: frame counter counts from 0 up to FRAME_CYCLES-1. At terminal count the counter clears and:
  - if stop=1, go to HALT;
  - otherwise go to ERASE.
- ERASE: draw_req=1, erase=1, x/y unchanged. Leave for MOVE on the cycle draw_done=1 is sampled.
- MOVE (exactly 1 cycle): update the position, then go to DRAW.
  - x_next = x+STEP if horizontal=1, else x-STEP.
  - y_next = y-STEP if vertical=1, else y+STEP.
  - Compute in 12 bits, then clamp each axis to [0, SCREEN_W-BALL_SIZE] for x and [0, SCREEN_H-BALL_SIZE] for y.
  - Underflow clamps to 0. Clamping guarantees the collision stage sees exact edge equality for any STEP.
- DRAW: draw_req=1, erase=0. On draw_done go to COLL.
- COLL (exactly 1 cycle): coll_enable=1, then go to WAIT. Direction flags updated by the collision stage on this edge are used at the next MOVE.
- HALT: halted=1, position frozen, no draw requests.
  - When serve=1: load START_X/START_Y, clear halted, go to DRAW. The old ball image is left to the screen-clear logic.
- Handshake rules:
  - draw_req and erase are registered outputs and stay stable while waiting.
  - x_ball/y_ball are stable whenever draw_req=1.
  - draw_done outside ERASE/DRAW is ignored.
  - draw_done in the same cycle draw_req rises is accepted.
- Outputs are functions of state only; coll_enable is high only in COLL.
- serve outside IDLE/HALT is ignored. stop is sampled only at WAIT terminal count.
- Steady-state frame latency is FRAME_CYCLES + erase time + 1 + draw time + 1 cycles.

Test Plan:
- Reset then release with serve=0, run 100 cycles -> x_ball=158, y_ball=118, draw_req=0, coll_enable=0, halted=0 throughout.
- serve=1 with FRAME_CYCLES=8 and draw_done returned 3 cycles after each request:
  - expect a draw (erase=0) at (158,118), then a coll_enable pulse;
  - after 8 WAIT cycles, an erase request at (158,118);
  - with horizontal=1, vertical=0, the next draw is at (159,119).
- Start at x=314 with horizontal=1 and STEP=4 -> x clamps to 316 (not 318). Start at y=2 with vertical=1 -> y clamps to 0.
- Assert stop=1 before WAIT terminal count -> HALT entered with no erase request, halted=1, position frozen.
  - Then pulse serve -> position reloads to (158,118), halted=0, a draw request follows.
- Drop reset_n to 0 while in ERASE with draw_req=1 -> next edge gives draw_req=0, IDLE, position (158,118).
  - A late draw_done after that is ignored.
- Hold draw_done low for 50 cycles in DRAW -> draw_req stays 1, erase=0, coordinates unchanged, no coll_enable pulse until draw_done arrives.

Source files
------------

// File: rtl/ball_motion_if.sv
// ---------------------------------------------------------------------------
// ball_motion_if
//
// Erase/redraw handshake between the ball sequencer and the VGA box drawer.
//
// Signals:
//   draw_req   requester -> drawer  box draw request; held until draw_done
//   erase      requester -> drawer  1 = paint background colour,
//                                   0 = paint ball colour (qualifies draw_req)
//   draw_done  drawer -> requester  1-cycle pulse; the current box is finished
//
// Modports:
//   master  the ball sequencer (drives draw_req/erase)
//   slave   the box drawer (drives draw_done)
// ---------------------------------------------------------------------------
interface ball_motion_if;
  logic draw_req;
  logic erase;
  logic draw_done;

  modport master (
    output draw_req,
    output erase,
    input  draw_done
  );

  modport slave (
    input  draw_req,
    input  erase,
    output draw_done
  );
endinterface

// File: rtl/ball_motion.sv
// ---------------------------------------------------------------------------
// ball_motion
//
// Frame-paced ball position sequencer for the air-hockey datapath. It holds
// the top-left corner of the ball and, once per frame tick, erases the old
// box, steps the position by STEP pixels per axis in the direction chosen by
// the collision stage, redraws the box, then gives the collision stage a
// one-cycle evaluation pulse.
//
// Ports:
//   clock        in   system clock
//   reset_n      in   synchronous, active-low reset
//   serve        in   start/restart the ball (level, sampled in IDLE/HALT)
//   horizontal   in   1 = move right (+x), 0 = move left (-x)
//   vertical     in   1 = move up (-y),    0 = move down (+y)
//   stop         in   goal condition, sampled at the WAIT terminal count
//   draw_bus     master side of the erase/redraw handshake with the drawer
//   x_ball       out  ball top-left x (11 bits)
//   y_ball       out  ball top-left y (11 bits)
//   coll_enable  out  1-cycle pulse; the collision stage evaluates on it
//   halted       out  ball stopped after a goal
// ---------------------------------------------------------------------------
module ball_motion #(
  parameter int FRAME_CYCLES = 833333,
  parameter int STEP         = 1,
  parameter int BALL_SIZE    = 4,
  parameter int SCREEN_W     = 320,
  parameter int SCREEN_H     = 240,
  parameter int START_X      = 158,
  parameter int START_Y      = 118
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          serve,
  input  logic          horizontal,
  input  logic          vertical,
  input  logic          stop,
  ball_motion_if.master draw_bus,
  output logic [10:0]   x_ball,
  output logic [10:0]   y_ball,
  output logic          coll_enable,
  output logic          halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ERASE,
    S_MOVE,
    S_DRAW,
    S_COLL,
    S_HALT
  } state_t;

  // FRAME_CYCLES is at least 2, so the counter is never narrower than 1 bit.
  localparam int CNT_W = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

  localparam logic [11:0] STEP_12  = 12'(STEP);
  localparam logic [11:0] X_MAX_12 = 12'(SCREEN_W - BALL_SIZE);
  localparam logic [11:0] Y_MAX_12 = 12'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] X_MAX_11 = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] Y_MAX_11 = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] X_START  = 11'(START_X);
  localparam logic [10:0] Y_START  = 11'(START_Y);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] frame_cnt;
  logic             frame_tick;
  logic [11:0]      x_sum;
  logic [11:0]      y_sum;
  logic [10:0]      x_next;
  logic [10:0]      y_next;

  assign frame_tick = (state == S_WAIT) && (frame_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. draw_done is only looked at in ERASE and DRAW, so a
  // stray pulse anywhere else has no effect.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (serve) begin
          state_next = S_DRAW;
        end
      end
      S_WAIT: begin
        if (frame_tick) begin
          state_next = stop ? S_HALT : S_ERASE;
        end
      end
      S_ERASE: begin
        if (draw_bus.draw_done) begin
          state_next = S_MOVE;
        end
      end
      S_MOVE: begin
        state_next = S_DRAW;
      end
      S_DRAW: begin
        if (draw_bus.draw_done) begin
          state_next = S_COLL;
        end
      end
      S_COLL: begin
        state_next = S_WAIT;
      end
      S_HALT: begin
        if (serve) begin
          state_next = S_DRAW;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Frame pacing counter; only runs in WAIT so every frame starts from 0.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      frame_cnt <= '0;
    end else if (state == S_WAIT) begin
      frame_cnt <= frame_tick ? '0 : frame_cnt + CNT_W'(1);
    end else begin
      frame_cnt <= '0;
    end
  end

  // Step arithmetic in 12 bits. The position is always within the screen, so
  // the sum can never reach 2048 from above; bit 11 set therefore means the
  // subtraction went below zero. Clamping to the edges (rather than letting
  // the ball overshoot) guarantees the collision stage sees exact edge
  // equality for any STEP.
  always_comb begin
    x_sum = horizontal ? ({1'b0, x_ball} + STEP_12) : ({1'b0, x_ball} - STEP_12);
    y_sum = vertical   ? ({1'b0, y_ball} - STEP_12) : ({1'b0, y_ball} + STEP_12);

    x_next = x_sum[10:0];
    if (x_sum[11]) begin
      x_next = '0;
    end else if (x_sum > X_MAX_12) begin
      x_next = X_MAX_11;
    end

    y_next = y_sum[10:0];
    if (y_sum[11]) begin
      y_next = '0;
    end else if (y_sum > Y_MAX_12) begin
      y_next = Y_MAX_11;
    end
  end

  // Position register. It only changes in MOVE (never while draw_req is up)
  // or on a serve, which is followed by a draw at the freshly loaded spot.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      x_ball <= X_START;
      y_ball <= Y_START;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (serve) begin
            x_ball <= X_START;
            y_ball <= Y_START;
          end
        end
        S_MOVE: begin
          x_ball <= x_next;
          y_ball <= y_next;
        end
        default: begin
          x_ball <= x_ball;
          y_ball <= y_ball;
        end
      endcase
    end
  end

  // Outputs are registered decodes of the next state, so they are glitch-free
  // and line up exactly with the state the machine is entering.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      draw_bus.draw_req <= 1'b0;
      draw_bus.erase    <= 1'b0;
      coll_enable       <= 1'b0;
      halted            <= 1'b0;
    end else begin
      draw_bus.draw_req <= (state_next == S_ERASE) || (state_next == S_DRAW);
      draw_bus.erase    <= (state_next == S_ERASE);
      coll_enable       <= (state_next == S_COLL);
      halted            <= (state_next == S_HALT);
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
// ---------------------------------------------------------------------------
// tb_ball_motion
//
// Directed bench for ball_motion. Two instances share clock and reset:
//   dut0  default geometry, STEP=1, short frame (8 cycles)
//   dut1  STEP=4 served next to the right/top edges to exercise clamping
// Expected draw requests are queued when stimulus is applied and popped when
// the DUT raises draw_req.
// ---------------------------------------------------------------------------
module tb_ball_motion;

  localparam int FC = 8;

  typedef struct packed {
    logic        erase;
    logic [10:0] x;
    logic [10:0] y;
  } draw_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  serve;
  logic [1:0]  horizontal;
  logic [1:0]  vertical;
  logic [1:0]  stop;
  logic [10:0] x0, y0, x1, y1;
  logic        coll0, coll1, halt0, halt1;

  int checks = 0;
  int failures = 0;
  draw_t sb[$];

  ball_motion_if bus0 ();
  ball_motion_if bus1 ();

  always #5 clock = ~clock;

  ball_motion #(
    .FRAME_CYCLES(FC), .STEP(1), .BALL_SIZE(4), .SCREEN_W(320), .SCREEN_H(240),
    .START_X(158), .START_Y(118)
  ) dut0 (
    .clock(clock), .reset_n(reset_n), .serve(serve[0]),
    .horizontal(horizontal[0]), .vertical(vertical[0]), .stop(stop[0]),
    .draw_bus(bus0), .x_ball(x0), .y_ball(y0),
    .coll_enable(coll0), .halted(halt0)
  );

  ball_motion #(
    .FRAME_CYCLES(FC), .STEP(4), .BALL_SIZE(4), .SCREEN_W(320), .SCREEN_H(240),
    .START_X(314), .START_Y(2)
  ) dut1 (
    .clock(clock), .reset_n(reset_n), .serve(serve[1]),
    .horizontal(horizontal[1]), .vertical(vertical[1]), .stop(stop[1]),
    .draw_bus(bus1), .x_ball(x1), .y_ball(y1),
    .coll_enable(coll1), .halted(halt1)
  );

  function automatic logic dreq(input int sel);
    return (sel != 0) ? bus1.draw_req : bus0.draw_req;
  endfunction

  function automatic logic ers(input int sel);
    return (sel != 0) ? bus1.erase : bus0.erase;
  endfunction

  function automatic logic col(input int sel);
    return (sel != 0) ? coll1 : coll0;
  endfunction

  function automatic logic hlt(input int sel);
    return (sel != 0) ? halt1 : halt0;
  endfunction

  function automatic logic [10:0] xb(input int sel);
    return (sel != 0) ? x1 : x0;
  endfunction

  function automatic logic [10:0] yb(input int sel);
    return (sel != 0) ? y1 : y0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic s, input logic h,
                               input logic v, input logic st);
    serve[sel]      = s;
    horizontal[sel] = h;
    vertical[sel]   = v;
    stop[sel]       = st;
  endtask

  task automatic setDone(input int sel, input logic v);
    if (sel != 0) bus1.draw_done = v;
    else          bus0.draw_done = v;
  endtask

  // Wait (bounded) for draw_req, then compare against the oldest queued entry.
  task automatic awaitDraw(input int sel, input int limit, input int lat_exp);
    int  lat = 0;
    bit  seen = 1'b0;
    draw_t exp_d;
    while (!seen && lat < limit) begin
      @(negedge clock);
      lat++;
      if (dreq(sel)) seen = 1'b1;
    end
    checkOutput("draw_seen", 32'(seen), 32'd1);
    if (seen) begin
      checkOutput("draw_latency", 32'(lat), 32'(lat_exp));
      checkOutput("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_d = sb.pop_front();
        checkOutput("draw_erase", 32'(ers(sel)), 32'(exp_d.erase));
        checkOutput("draw_x", 32'(xb(sel)), 32'(exp_d.x));
        checkOutput("draw_y", 32'(yb(sel)), 32'(exp_d.y));
      end
    end
  endtask

  // Drawer model: keep the request waiting 'delay' cycles, checking it stays
  // stable, then return a one-cycle draw_done.
  task automatic respond(input int sel, input int delay);
    logic        e_hold;
    logic [10:0] x_hold, y_hold;
    e_hold = ers(sel);
    x_hold = xb(sel);
    y_hold = yb(sel);
    for (int i = 0; i < delay; i++) begin
      @(negedge clock);
      checkOutput("req_held", 32'({dreq(sel), ers(sel), col(sel), xb(sel), yb(sel)}),
                  32'({1'b1, e_hold, 1'b0, x_hold, y_hold}));
    end
    setDone(sel, 1'b1);
    @(negedge clock);
    setDone(sel, 1'b0);
  endtask

  // Called right after a DRAW handshake completes.
  task automatic checkCollPulse(input int sel);
    checkOutput("coll_high", 32'({col(sel), dreq(sel)}), 32'({1'b1, 1'b0}));
    @(negedge clock);
    checkOutput("coll_low", 32'({col(sel), dreq(sel)}), 32'({1'b0, 1'b0}));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  lat;
    bit  seen;

    reset_n = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus0.draw_done = 1'b0;
    bus1.draw_done = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Reset state and idle with serve low.
    checkOutput("rst_pos_dut1", 32'({x1, y1}), 32'({11'd314, 11'd2}));
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      checkOutput("idle_hold", 32'({dreq(0), col(0), hlt(0), x0, y0}),
                  32'({1'b0, 1'b0, 1'b0, 11'd158, 11'd118}));
    end

    // Edge clamping with STEP=4: x 314->316 (not 318), y 2->0.
    $display("[TB] clamp sequence");
    applyStimulus(1, 1'b1, 1'b1, 1'b1, 1'b0);
    sb.push_back('{erase: 1'b0, x: 11'd314, y: 11'd2});
    awaitDraw(1, 4, 1);
    applyStimulus(1, 1'b0, 1'b1, 1'b1, 1'b0);
    respond(1, 3);
    checkCollPulse(1);
    sb.push_back('{erase: 1'b1, x: 11'd314, y: 11'd2});
    awaitDraw(1, 20, FC);
    respond(1, 2);
    sb.push_back('{erase: 1'b0, x: 11'd316, y: 11'd0});
    awaitDraw(1, 4, 1);

    // Serve and a normal frame moving right/down.
    $display("[TB] serve and move");
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0);
    sb.push_back('{erase: 1'b0, x: 11'd158, y: 11'd118});
    awaitDraw(0, 4, 1);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0);
    respond(0, 3);
    checkCollPulse(0);
    sb.push_back('{erase: 1'b1, x: 11'd158, y: 11'd118});
    awaitDraw(0, 20, FC);
    respond(0, 3);
    sb.push_back('{erase: 1'b0, x: 11'd159, y: 11'd119});
    awaitDraw(0, 4, 1);
    respond(0, 3);
    checkCollPulse(0);

    // Goal: stop seen at terminal count -> HALT with no erase.
    $display("[TB] goal halt");
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b1);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clock);
      lat++;
      checkOutput("no_req_before_halt", 32'(dreq(0)), 32'd0);
      if (hlt(0)) seen = 1'b1;
    end
    checkOutput("halt_seen", 32'(seen), 32'd1);
    checkOutput("halt_latency", 32'(lat), 32'(FC));
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checkOutput("halt_frozen", 32'({dreq(0), hlt(0), col(0), x0, y0}),
                  32'({1'b0, 1'b1, 1'b0, 11'd159, 11'd119}));
    end

    // Re-serve from HALT reloads the start position.
    applyStimulus(0, 1'b1, 1'b0, 1'b1, 1'b0);
    sb.push_back('{erase: 1'b0, x: 11'd158, y: 11'd118});
    awaitDraw(0, 4, 1);
    checkOutput("halt_cleared", 32'(hlt(0)), 32'd0);
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0);
    respond(0, 3);
    checkCollPulse(0);
    sb.push_back('{erase: 1'b1, x: 11'd158, y: 11'd118});
    awaitDraw(0, 20, FC);
    respond(0, 3);
    sb.push_back('{erase: 1'b0, x: 11'd157, y: 11'd117});
    awaitDraw(0, 4, 1);
    respond(0, 3);
    checkCollPulse(0);
    sb.push_back('{erase: 1'b1, x: 11'd157, y: 11'd117});
    awaitDraw(0, 20, FC);

    // Reset in the middle of the erase handshake.
    $display("[TB] reset mid-erase");
    reset_n = 1'b0;
    @(negedge clock);
    checkOutput("rst_mid_erase", 32'({dreq(0), ers(0), col(0), hlt(0), x0, y0}),
                32'({1'b0, 1'b0, 1'b0, 1'b0, 11'd158, 11'd118}));
    reset_n = 1'b1;
    setDone(0, 1'b1);
    @(negedge clock);
    setDone(0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checkOutput("late_done_ignored", 32'({dreq(0), col(0), x0, y0}),
                  32'({1'b0, 1'b0, 11'd158, 11'd118}));
    end

    // Slow drawer: draw_done withheld for 50 cycles.
    $display("[TB] slow drawer");
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0);
    sb.push_back('{erase: 1'b0, x: 11'd158, y: 11'd118});
    awaitDraw(0, 4, 1);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0);
    respond(0, 50);
    checkCollPulse(0);

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
